// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the sequential ALU.
//   op_e     : operation encoding carried on OP (codes 5-7 are illegal)
//   state_e  : control FSM states (IDLE -> RUN -> FIN -> IDLE)
//   DEFAULT_W: default operand width
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_EXP = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage : alu_pkg

// File: rtl/alu_div_seq.sv
// ---------------------------------------------------------------------------
// alu_div_seq -- iterative signed restoring divider, one quotient bit/cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load a_i / b_i and begin (b_i must be non-zero)
//   a_i, b_i      : signed dividend / divisor
//   done_o        : high during the cycle whose edge retires the last step
//   quo_o, rem_o  : signed quotient / remainder, valid while done_o is high
// Quotient truncates toward zero; the remainder takes the dividend's sign.
// The result outputs are formed from the final step's next-state value so
// the caller can capture them on the same edge the divider finishes.
// ---------------------------------------------------------------------------
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o
);

    localparam logic [W-1:0] LAST = W'(W - 1);

    logic         active_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] quo_q;   // dividend magnitude shifts out, quotient bits shift in
    logic [W-1:0] rem_q;
    logic [W-1:0] dvs_q;
    logic         negq_q;
    logic         negr_q;

    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W:0]   shifted;
    logic [W:0]   diff;
    logic         fits;
    logic [W-1:0] rem_step;
    logic [W-1:0] quo_step;

    // Magnitudes fit in W unsigned bits, including -2^(W-1).
    assign a_mag    = a_i[W-1] ? -a_i : a_i;
    assign b_mag    = b_i[W-1] ? -b_i : b_i;

    assign shifted  = {rem_q, quo_q[W-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign fits     = ~diff[W];
    assign rem_step = fits ? diff[W-1:0] : shifted[W-1:0];
    assign quo_step = {quo_q[W-2:0], fits};

    assign done_o   = active_q && (cnt_q == LAST);
    assign quo_o    = negq_q ? -quo_step : quo_step;
    assign rem_o    = negr_q ? -rem_step : rem_step;

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            quo_q    <= a_mag;
            rem_q    <= '0;
            dvs_q    <= b_mag;
            negq_q   <= a_i[W-1] ^ b_i[W-1];
            negr_q   <= a_i[W-1];
        end else if (active_q) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule : alu_div_seq

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- multi-cycle signed ALU (ADD, SUB, MUL, DIV, EXP).
//   CLK, RST_N : clock, asynchronous active-low reset
//   START      : request pulse, sampled only in IDLE
//   OP, A, B   : operation and signed operands, latched when START accepted
//   BUSY       : high in RUN and FIN
//   DONE       : single-cycle pulse, high exactly in FIN
//   R, OVF     : registered 2*W result and error flag, written on FIN entry
// Errors (illegal OP, divide by zero, -2^(W-1)/-1, negative exponent) are
// detected at accept time and spend one RUN cycle before FIN.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    input  logic [2:0]     OP,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*W-1:0] R,
    output logic           OVF
);

    localparam logic [W-1:0]   MUL_LAST = W'(W - 1);
    localparam logic [W-1:0]   CNT_ONE  = W'(1);
    localparam logic [2*W-1:0] R_ONE    = (2*W)'(1);
    localparam logic [W-1:0]   MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic                  err_q, err_d;
    logic [W-1:0]          a_q, a_d;
    logic [W-1:0]          b_q, b_d;
    logic [W-1:0]          cnt_q, cnt_d;
    logic [2*W-1:0]        mcand_q, mcand_d;
    logic [W-1:0]          mplier_q, mplier_d;
    logic [2*W-1:0]        prod_q, prod_d;
    logic                  neg_q, neg_d;
    logic signed [3*W-1:0] acc_q, acc_d;
    logic [2*W-1:0]        r_q, r_d;
    logic                  ovf_q, ovf_d;

    logic                  accept;
    logic                  start_err;
    logic [W-1:0]          a_mag;
    logic [W-1:0]          b_mag;
    logic [2*W-1:0]        prod_step;
    logic signed [3*W-1:0] base_ext;
    logic signed [3*W-1:0] acc_step;
    logic                  acc_out_of_range;

    logic                  div_start;
    logic                  div_done;
    logic [W-1:0]          div_quo;
    logic [W-1:0]          div_rem;

    assign accept = (state_q == S_IDLE) && START;

    assign start_err = (OP > OP_EXP)
                    || ((OP == OP_DIV) && (B == '0))
                    || ((OP == OP_DIV) && (A == MIN_NEG) && (&B))
                    || ((OP == OP_EXP) && B[W-1]);

    assign a_mag = A[W-1] ? -A : A;
    assign b_mag = B[W-1] ? -B : B;

    // Shift-add on magnitudes: multiplicand moves left, multiplier right.
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    // The accumulator stays inside the signed 2*W range between steps, so a
    // 3*W-bit product with the sign-extended base is always exact.
    assign base_ext  = {{(2*W){a_q[W-1]}}, a_q};
    assign acc_step  = acc_q * base_ext;
    assign acc_out_of_range = !((&acc_step[3*W-1:2*W-1]) || (~|acc_step[3*W-1:2*W-1]));

    assign div_start = accept && (OP == OP_DIV) && !start_err;

    alu_div_seq #(.W(W)) u_div (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .start_i (div_start),
        .a_i     (A),
        .b_i     (B),
        .done_o  (div_done),
        .quo_o   (div_quo),
        .rem_o   (div_rem)
    );

    // NOTE: every variable gets its hold/default value first so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        err_d    = err_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        r_d      = r_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d  = S_RUN;
                    op_d     = op_e'(OP);
                    err_d    = start_err;
                    a_d      = A;
                    b_d      = B;
                    cnt_d    = (OP == OP_EXP) ? B : '0;
                    mcand_d  = {{W{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    prod_d   = '0;
                    neg_d    = A[W-1] ^ B[W-1];
                    acc_d    = (3*W)'(1);
                end
            end

            S_RUN: begin
                if (err_q) begin
                    state_d = S_FIN;
                    r_d     = '0;
                    ovf_d   = 1'b1;
                end else begin
                    case (op_q)
                        OP_ADD: begin
                            state_d = S_FIN;
                            r_d     = {{W{a_q[W-1]}}, a_q} + {{W{b_q[W-1]}}, b_q};
                            ovf_d   = 1'b0;
                        end
                        OP_SUB: begin
                            state_d = S_FIN;
                            r_d     = {{W{a_q[W-1]}}, a_q} - {{W{b_q[W-1]}}, b_q};
                            ovf_d   = 1'b0;
                        end
                        OP_MUL: begin
                            prod_d   = prod_step;
                            mcand_d  = {mcand_q[2*W-2:0], 1'b0};
                            mplier_d = {1'b0, mplier_q[W-1:1]};
                            cnt_d    = cnt_q + 1'b1;
                            if (cnt_q == MUL_LAST) begin
                                state_d = S_FIN;
                                r_d     = neg_q ? -prod_step : prod_step;
                                ovf_d   = 1'b0;
                            end
                        end
                        OP_DIV: begin
                            if (div_done) begin
                                state_d = S_FIN;
                                r_d     = {div_quo, div_rem};
                                ovf_d   = 1'b0;
                            end
                        end
                        OP_EXP: begin
                            if (cnt_q == '0) begin
                                // x^0 = 1, including 0^0.
                                state_d = S_FIN;
                                r_d     = R_ONE;
                                ovf_d   = 1'b0;
                            end else if (acc_out_of_range) begin
                                // Stop at the first product that escapes 2*W.
                                state_d = S_FIN;
                                r_d     = '0;
                                ovf_d   = 1'b1;
                            end else begin
                                acc_d = acc_step;
                                cnt_d = cnt_q - 1'b1;
                                if (cnt_q == CNT_ONE) begin
                                    state_d = S_FIN;
                                    r_d     = acc_step[2*W-1:0];
                                    ovf_d   = 1'b0;
                                end
                            end
                        end
                        default: begin
                            state_d = S_FIN;
                            r_d     = '0;
                            ovf_d   = 1'b1;
                        end
                    endcase
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: every register, datapath included, is cleared by reset so an
    // aborted operation leaves no stale state behind.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
            ovf_q    <= ovf_d;
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = (state_q == S_FIN);
    assign R    = r_q;
    assign OVF  = ovf_q;

endmodule : alu_seq
